// File: rtl/pkt_to_msg.sv
// ============================================================================
// pkt_to_msg : reassembles a header + payload flit packet into a bus message
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BUS_DATA_WIDTH
  `define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_ADDRESS_WIDTH
  `define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
  `define BUS_SEL_WIDTH 4
`endif
`ifndef MAX_BURST_LENGHT
  `define MAX_BURST_LENGHT 4
`endif
`ifndef FLIT_WIDTH
  `define FLIT_WIDTH 36
`endif

module pkt_to_msg #(
  parameter int FLIT_W    = `FLIT_WIDTH,
  parameter int DATA_W    = `BUS_DATA_WIDTH,
  parameter int ADDR_W    = `BUS_ADDRESS_WIDTH,
  parameter int SEL_W     = `BUS_SEL_WIDTH,
  parameter int MAX_BURST = `MAX_BURST_LENGHT,
  parameter int BL_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [FLIT_W-1:0]             flit_i,
  input  logic                          flit_valid_i,
  input  logic                          flit_tail_i,
  output logic                          flit_ready_o,
  output logic [MAX_BURST*DATA_W-1:0]   data_o,
  output logic [MAX_BURST*SEL_W-1:0]    sel_o,
  output logic [ADDR_W-1:0]             address_o,
  output logic                          WE_O,
  output logic [BL_W:0]                 burst_len_o,
  output logic                          msg_valid_o,
  input  logic                          msg_ready_i,
  output logic                          err_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PRESENT = 2'd2,
    S_DROP    = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [BL_W-1:0]               cnt_q, cnt_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic                          we_q, we_d;
  logic [BL_W:0]                 len_q, len_d;
  logic [MAX_BURST*DATA_W-1:0]   data_q, data_d;
  logic [MAX_BURST*SEL_W-1:0]    sel_q, sel_d;
  logic                          err_q, err_d;

  logic                          last_word;
  logic                          unused_flit;

  // Not every flit bit carries a field in every flit type.
  assign unused_flit = ^flit_i;

  assign last_word = ({1'b0, cnt_q} + (BL_W+1)'(1)) == len_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    len_d   = len_q;
    data_d  = data_q;
    sel_d   = sel_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flit_valid_i) begin
          addr_d = flit_i[ADDR_W-1:0];
          we_d   = flit_i[ADDR_W];
          len_d  = {1'b0, flit_i[ADDR_W+BL_W:ADDR_W+1]} + (BL_W+1)'(1);
          data_d = '0;
          sel_d  = '0;
          cnt_d  = '0;
          case ({flit_i[ADDR_W], flit_tail_i})
            2'b01:   state_d = S_PRESENT;
            2'b00: begin
              err_d   = 1'b1;
              state_d = S_DROP;
            end
            2'b11: begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
            default: state_d = S_COLLECT;
          endcase
        end
      end

      S_COLLECT: begin
        if (flit_valid_i) begin
          for (int k = 0; k < MAX_BURST; k++) begin
            if (cnt_q == BL_W'(k)) begin
              data_d[k*DATA_W +: DATA_W] = flit_i[DATA_W-1:0];
              sel_d[k*SEL_W +: SEL_W]    = flit_i[DATA_W +: SEL_W];
            end
          end
          cnt_d = cnt_q + BL_W'(1);
          if (last_word) begin
            if (flit_tail_i) begin
              state_d = S_PRESENT;
            end else begin
              err_d   = 1'b1;
              state_d = S_DROP;
            end
          end else if (flit_tail_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_PRESENT: begin
        if (msg_ready_i) begin
          state_d = S_IDLE;
        end
      end

      S_DROP: begin
        // Error already reported when the packet went bad; just sink it.
        if (flit_valid_i && flit_tail_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      len_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      len_q   <= len_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign flit_ready_o = (state_q != S_PRESENT);
  assign msg_valid_o  = (state_q == S_PRESENT);
  assign data_o       = data_q;
  assign sel_o        = sel_q;
  assign address_o    = addr_q;
  assign WE_O         = we_q;
  assign burst_len_o  = len_q;
  assign err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pkt_to_msg.sv
// ============================================================================
// tb_pkt_to_msg : table-driven and directed checks for pkt_to_msg
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkt_to_msg;

  localparam int FW = 36;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int MB = 4;
  localparam int BW = 2;

  logic              clk;
  logic              rst_n;
  logic [FW-1:0]     flit_i;
  logic              flit_valid_i;
  logic              flit_tail_i;
  logic              flit_ready_o;
  logic [MB*DW-1:0]  data_o;
  logic [MB*SW-1:0]  sel_o;
  logic [AW-1:0]     address_o;
  logic              WE_O;
  logic [BW:0]       burst_len_o;
  logic              msg_valid_o;
  logic              msg_ready_i;
  logic              err_o;

  int checks   = 0;
  int failures = 0;

  pkt_to_msg #(
    .FLIT_W(FW), .DATA_W(DW), .ADDR_W(AW), .SEL_W(SW), .MAX_BURST(MB), .BL_W(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flit_i(flit_i), .flit_valid_i(flit_valid_i), .flit_tail_i(flit_tail_i),
    .flit_ready_o(flit_ready_o),
    .data_o(data_o), .sel_o(sel_o), .address_o(address_o), .WE_O(WE_O),
    .burst_len_o(burst_len_o), .msg_valid_o(msg_valid_o),
    .msg_ready_i(msg_ready_i), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0]    flit;
    logic             v, t, m;
    logic             e_rdy, e_mv, e_err, e_we;
    logic [BW:0]      e_len;
    logic [AW-1:0]    e_addr;
    logic [MB*DW-1:0] e_data;
    logic [MB*SW-1:0] e_sel;
  } vec_t;

  vec_t vq[$];

  function automatic logic [FW-1:0] hdr(input logic [AW-1:0] a, input logic we,
                                        input logic [BW-1:0] lm1);
    logic [FW-1:0] f;
    f = '0;
    f[AW-1:0] = a;
    f[AW] = we;
    f[AW+BW:AW+1] = lm1;
    return f;
  endfunction

  function automatic logic [FW-1:0] pay(input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [FW-1:0] f;
    f = '0;
    f[DW-1:0] = d;
    f[DW +: SW] = s;
    return f;
  endfunction

  task automatic add(input logic [FW-1:0] f, input logic v, input logic t, input logic m,
                     input logic r, input logic mv, input logic er, input logic we,
                     input logic [BW:0] len, input logic [AW-1:0] a,
                     input logic [MB*DW-1:0] d, input logic [MB*SW-1:0] s);
    vec_t x;
    x.flit = f; x.v = v; x.t = t; x.m = m;
    x.e_rdy = r; x.e_mv = mv; x.e_err = er; x.e_we = we;
    x.e_len = len; x.e_addr = a; x.e_data = d; x.e_sel = s;
    vq.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic r, input logic mv, input logic er,
                            input logic we, input logic [BW:0] len, input logic [AW-1:0] a,
                            input logic [MB*DW-1:0] d, input logic [MB*SW-1:0] s);
    chk({tag, ".ready"}, 128'(flit_ready_o), 128'(r));
    chk({tag, ".mvalid"}, 128'(msg_valid_o), 128'(mv));
    chk({tag, ".err"}, 128'(err_o), 128'(er));
    chk({tag, ".we"}, 128'(WE_O), 128'(we));
    chk({tag, ".len"}, 128'(burst_len_o), 128'(len));
    chk({tag, ".addr"}, 128'(address_o), 128'(a));
    chk({tag, ".data"}, 128'(data_o), 128'(d));
    chk({tag, ".sel"}, 128'(sel_o), 128'(s));
  endtask

  task automatic drive(input logic [FW-1:0] f, input logic v, input logic t, input logic m);
    flit_i = f; flit_valid_i = v; flit_tail_i = t; msg_ready_i = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    check_outs("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // idle with msg_ready high: nothing moves
    add(hdr(0, 0, 0), 0, 0, 1,                 1, 0, 0, 0, 0, 0, 0, 0);
    // write burst 2
    add(hdr(32'h100, 1, 1), 1, 0, 0,           1, 0, 0, 1, 2, 32'h100, 0, 0);
    add(pay(32'hAAAA, 4'hF), 1, 0, 0,          1, 0, 0, 1, 2, 32'h100, 128'hAAAA, 16'hF);
    add(pay(32'hDEAD, 4'h9), 0, 1, 0,          1, 0, 0, 1, 2, 32'h100, 128'hAAAA, 16'hF);
    add(pay(32'hBBBB, 4'h3), 1, 1, 0,          0, 1, 0, 1, 2, 32'h100, 128'h0000BBBB_0000AAAA, 16'h3F);
    add(0, 0, 0, 0,                            0, 1, 0, 1, 2, 32'h100, 128'h0000BBBB_0000AAAA, 16'h3F);
    add(0, 0, 0, 1,                            1, 0, 0, 1, 2, 32'h100, 128'h0000BBBB_0000AAAA, 16'h3F);
    // read
    add(hdr(32'h40, 0, 0), 1, 1, 0,            0, 1, 0, 0, 1, 32'h40, 0, 0);
    add(0, 0, 0, 1,                            1, 0, 0, 0, 1, 32'h40, 0, 0);
    // early tail on len-4 write
    add(hdr(32'h200, 1, 3), 1, 0, 0,           1, 0, 0, 1, 4, 32'h200, 0, 0);
    add(pay(32'h11, 4'h1), 1, 0, 0,            1, 0, 0, 1, 4, 32'h200, 128'h11, 16'h1);
    add(pay(32'h22, 4'h2), 1, 1, 0,            1, 0, 1, 1, 4, 32'h200, 128'h00000022_00000011, 16'h21);
    add(0, 0, 0, 0,                            1, 0, 0, 1, 4, 32'h200, 128'h00000022_00000011, 16'h21);
    // missing tail on len-1 write, then two dropped flits
    add(hdr(32'h300, 1, 0), 1, 0, 0,           1, 0, 0, 1, 1, 32'h300, 0, 0);
    add(pay(32'h33, 4'h4), 1, 0, 0,            1, 0, 1, 1, 1, 32'h300, 128'h33, 16'h4);
    add(pay(32'h44, 4'h5), 1, 0, 0,            1, 0, 0, 1, 1, 32'h300, 128'h33, 16'h4);
    add(pay(32'h55, 4'h6), 1, 1, 0,            1, 0, 0, 1, 1, 32'h300, 128'h33, 16'h4);
    // write header carrying tail
    add(hdr(32'h500, 1, 0), 1, 1, 0,           1, 0, 1, 1, 1, 32'h500, 0, 0);
    // read header without tail, then drop to tail
    add(hdr(32'h600, 0, 1), 1, 0, 0,           1, 0, 1, 0, 2, 32'h600, 0, 0);
    add(pay(32'h66, 4'h7), 1, 0, 0,            1, 0, 0, 0, 2, 32'h600, 0, 0);
    add(pay(32'h77, 4'h8), 1, 1, 0,            1, 0, 0, 0, 2, 32'h600, 0, 0);
    // full MAX_BURST write
    add(hdr(32'h700, 1, 3), 1, 0, 0,           1, 0, 0, 1, 4, 32'h700, 0, 0);
    add(pay(32'h1, 4'hF), 1, 0, 0,             1, 0, 0, 1, 4, 32'h700, 128'h1, 16'hF);
    add(pay(32'h2, 4'hE), 1, 0, 0,             1, 0, 0, 1, 4, 32'h700, 128'h2_00000001, 16'hEF);
    add(pay(32'h3, 4'hD), 1, 0, 0,             1, 0, 0, 1, 4, 32'h700, 128'h3_00000002_00000001, 16'hDEF);
    add(pay(32'h4, 4'hC), 1, 1, 0,             0, 1, 0, 1, 4, 32'h700,
        128'h00000004_00000003_00000002_00000001, 16'hCDEF);
    add(0, 0, 0, 1,                            1, 0, 0, 1, 4, 32'h700,
        128'h00000004_00000003_00000002_00000001, 16'hCDEF);

    foreach (vq[i]) begin
      drive(vq[i].flit, vq[i].v, vq[i].t, vq[i].m);
      step();
      check_outs($sformatf("v%0d", i), vq[i].e_rdy, vq[i].e_mv, vq[i].e_err, vq[i].e_we,
                 vq[i].e_len, vq[i].e_addr, vq[i].e_data, vq[i].e_sel);
    end

    // backpressure with a second header waiting
    drive(hdr(32'h80, 0, 0), 1, 1, 0);
    step();
    check_outs("bp.first", 0, 1, 0, 0, 1, 32'h80, 0, 0);
    drive(hdr(32'h90, 0, 0), 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_outs($sformatf("bp.hold%0d", i), 0, 1, 0, 0, 1, 32'h80, 0, 0);
    end
    drive(hdr(32'h90, 0, 0), 1, 1, 1);
    step();
    check_outs("bp.xfer", 1, 0, 0, 0, 1, 32'h80, 0, 0);
    drive(hdr(32'h90, 0, 0), 1, 1, 0);
    step();
    check_outs("bp.second", 0, 1, 0, 0, 1, 32'h90, 0, 0);
    drive('0, 0, 0, 1);
    step();
    check_outs("bp.done", 1, 0, 0, 0, 1, 32'h90, 0, 0);

    // asynchronous reset mid-packet
    drive(hdr(32'h900, 1, 1), 1, 0, 0);
    step();
    drive(pay(32'hCC, 4'h7), 1, 0, 0);
    step();
    check_outs("rst.pre", 1, 0, 0, 1, 2, 32'h900, 128'hCC, 16'h7);
    drive('0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_outs("rst.async", 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_outs("rst.held", 1, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(hdr(32'hA0, 0, 0), 1, 1, 0);
    step();
    check_outs("rst.clean", 0, 1, 0, 0, 1, 32'hA0, 0, 0);
    drive('0, 0, 0, 1);
    step();
    check_outs("rst.done", 1, 0, 0, 0, 1, 32'hA0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pkt_to_msg.md
PKT_TO_MSG -- requirements
Module: pkt_to_msg

Interface
REQ-001: Parameters, one per line: name, default, meaning.
  FLIT_W, `FLIT_WIDTH, flit width; SHALL be >= max(ADDR_W+1+BL_W, DATA_W+SEL_W).
  DATA_W, `BUS_DATA_WIDTH, bus data word width.
  ADDR_W, `BUS_ADDRESS_WIDTH, bus address width.
  SEL_W, `BUS_SEL_WIDTH, byte-select width per word.
  MAX_BURST, `MAX_BURST_LENGHT, max words per message.
  BL_W, $clog2(MAX_BURST) (min 1), burst-length field width.
REQ-002: Ports, one per line: name, direction, width, meaning.
  clk  in  1  clock; all state changes on the rising edge.
  rst_n  in  1  asynchronous active-low reset.
  flit_i  in  FLIT_W  incoming flit.
  flit_valid_i  in  1  flit_i valid.
  flit_tail_i  in  1  flit_i is the last flit of its packet.
  flit_ready_o  out  1  block accepts a flit this cycle.
  data_o  out  MAX_BURST*DATA_W  assembled data; word k at [k*DATA_W +: DATA_W].
  sel_o  out  MAX_BURST*SEL_W  assembled selects, same indexing.
  address_o  out  ADDR_W  bus address.
  WE_O  out  1  1 = write message, 0 = read request.
  burst_len_o  out  BL_W+1  word count, range 1..MAX_BURST.
  msg_valid_o  out  1  message fields valid.
  msg_ready_i  in  1  consumer takes the message.
  err_o  out  1  one-cycle pulse on a malformed packet.

Function
REQ-003: Flit transfer occurs when flit_valid_i && flit_ready_o; message transfer occurs when msg_valid_o && msg_ready_i.
REQ-004: Header flit fields: address [ADDR_W-1:0]; WE [ADDR_W]; burst length minus 1 [ADDR_W+BL_W:ADDR_W+1].
REQ-005: Payload flit fields: data word [DATA_W-1:0]; sel [DATA_W+SEL_W-1:DATA_W].
REQ-006: FSM states SHALL be IDLE, COLLECT, PRESENT, DROP.
REQ-007: flit_ready_o SHALL be 1 in IDLE, COLLECT and DROP, and 0 in PRESENT.
REQ-008: IDLE, header transferred: latch address, WE and burst length; clear data and sel buffers to 0; clear the word counter.
  - WE=0 with tail: go to PRESENT.
  - WE=0 without tail: pulse err_o, go to DROP.
  - WE=1 with tail: pulse err_o, stay in IDLE.
  - WE=1 without tail: go to COLLECT.
REQ-009: COLLECT, payload flit transferred: store it in word slot = counter, then increment the counter.
  - Tail on the final word (counter == burst length-1): go to PRESENT.
  - Tail earlier: pulse err_o, go to IDLE.
  - Final word without tail: pulse err_o, go to DROP.
REQ-010: DROP: discard accepted flits; on the tail flit go to IDLE; err_o is not pulsed again.
REQ-011: PRESENT: msg_valid_o=1 and all message outputs are held stable until transfer; on transfer go to IDLE with msg_valid_o=0 in the next cycle.
REQ-012: msg_valid_o SHALL rise in the cycle after the tail flit transfer (latency 1); the next header is accepted no earlier than the cycle after message transfer.
REQ-013: Slots beyond burst_len_o SHALL read 0 in data_o and sel_o; a read message has all data and sel zero.
REQ-014: burst_len_o = header field + 1, zero-extended to BL_W+1 bits.
REQ-015: Flit transfers with flit_valid_i low SHALL NOT change state; msg_ready_i is ignored outside PRESENT.
REQ-016: err_o SHALL be registered, high for exactly one cycle per malformed packet.

Reset
REQ-017: With rst_n low, asynchronously: state=IDLE, counter=0, all buffers 0, msg_valid_o=0, err_o=0, WE_O=0, address_o=0, burst_len_o=0; flit_ready_o=1 after deassertion.
REQ-018: Reset mid-packet or in PRESENT SHALL discard the partial or pending message without pulsing err_o.

Verification
REQ-019: Write, burst 2: header (addr 0x100, WE=1, len field 1), flits (0xAAAA, sel 0xF), (0xBBBB, sel 0x3, tail) -> next cycle msg_valid_o=1, WE_O=1, burst_len_o=2, word0=0xAAAA, word1=0xBBBB, sel 0xF/0x3, other slots 0.
REQ-020: Read: single header flit with tail (addr 0x40, WE=0) -> msg_valid_o=1, WE_O=0, burst_len_o=1, data_o=0.
REQ-021: Backpressure: msg_ready_i held 0 for 5 cycles with a second header offered -> flit_ready_o=0 and outputs stable; after transfer, the second header is accepted.
REQ-022: Early tail: write of len 4 with tail on the 2nd payload flit -> one err_o pulse, no msg_valid_o, back in IDLE.
REQ-023: Missing tail: len 1 write, 1st payload flit without tail, then 2 more flits with the last tail -> one err_o pulse, extra flits dropped, IDLE afterwards.
REQ-024: Reset asserted after 1 payload flit -> all outputs 0 immediately; a clean packet after release decodes correctly.
